// File: rtl/clock_time_pkg.sv
// Shared constants, field types and the hour-hand position helper for clock_time.
package clock_time_pkg;

    localparam int unsigned SECS_PER_MIN  = 60;
    localparam int unsigned MINS_PER_HOUR = 60;
    localparam int unsigned HOURS         = 12;
    localparam int unsigned POS_STEPS     = 60;
    localparam int unsigned HOUR_POS_STEP = 5;

    typedef logic [5:0] time6_t;
    typedef logic [3:0] hour_t;

    // Hour hand moves one step every MINS_PER_HOUR / HOUR_POS_STEP minutes.
    function automatic time6_t hour_pos_f(input hour_t h, input time6_t m);
        return ({2'b00, h} * time6_t'(HOUR_POS_STEP)) +
               (m / time6_t'(MINS_PER_HOUR / HOUR_POS_STEP));
    endfunction

endpackage

// File: rtl/frame_debounce.sv
// Button synchronizer plus frame-sampled debouncer; emits a one-cycle press event
// coincident with the frame_start that accepts the pressed level.
module frame_debounce #(
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_frame_start,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int unsigned CntW = $clog2(DEBOUNCE_FRAMES + 1);

    logic            r_sync1;
    logic            r_sync2;
    logic            r_level;
    logic [CntW-1:0] r_cnt;
    logic [CntW-1:0] w_cnt_d;
    logic            w_level_d;
    logic            w_pressed;
    logic            w_done;

    assign w_pressed = ~r_sync2;
    assign w_done    = (r_cnt == CntW'(DEBOUNCE_FRAMES - 1));

    always_comb begin
        w_cnt_d   = r_cnt;
        w_level_d = r_level;
        if (i_frame_start) begin
            if (w_pressed != r_level) begin
                if (w_done) begin
                    w_level_d = w_pressed;
                    w_cnt_d   = '0;
                end else begin
                    w_cnt_d = r_cnt + CntW'(1);
                end
            end else begin
                // Any sample matching the accepted level restarts the run.
                w_cnt_d = '0;
            end
        end
    end

    assign o_press = i_frame_start & w_pressed & ~r_level & w_done;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_level <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_sync1 <= i_btn_n;
            r_sync2 <= r_sync1;
            r_level <= w_level_d;
            r_cnt   <= w_cnt_d;
        end
    end

endmodule

// File: rtl/clock_time.sv
// Wall-clock timekeeper: frame-derived 1 Hz tick, set buttons, and hand positions
// that only change on the cycle after frame_start.
module clock_time
    import clock_time_pkg::*;
#(
    parameter int unsigned FRAMES_PER_SEC  = 75,
    parameter int unsigned DEBOUNCE_FRAMES = 3
) (
    input  logic   vga_clk,
    input  logic   vga_rst_n,
    input  logic   frame_start,
    input  logic   btn_min_n,
    input  logic   btn_hour_n,
    input  logic   run,
    output time6_t sec,
    output time6_t min,
    output hour_t  hour,
    output time6_t sec_pos,
    output time6_t min_pos,
    output time6_t hour_pos,
    output logic   pos_update
);

    logic [6:0] r_frame;
    logic [6:0] w_frame_d;
    time6_t     r_sec;
    time6_t     r_min;
    hour_t      r_hour;
    time6_t     w_sec_d;
    time6_t     w_min_d;
    hour_t      w_hour_d;
    time6_t     r_sec_pos;
    time6_t     r_min_pos;
    time6_t     r_hour_pos;
    logic       r_pos_update;
    logic       w_min_press;
    logic       w_hour_press;
    logic       w_tick;

    frame_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_db_min (
        .i_clk        (vga_clk),
        .i_rst_n      (vga_rst_n),
        .i_frame_start(frame_start),
        .i_btn_n      (btn_min_n),
        .o_press      (w_min_press)
    );

    frame_debounce #(
        .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
    ) u_db_hour (
        .i_clk        (vga_clk),
        .i_rst_n      (vga_rst_n),
        .i_frame_start(frame_start),
        .i_btn_n      (btn_hour_n),
        .o_press      (w_hour_press)
    );

    assign w_tick = frame_start & run & (r_frame == 7'(FRAMES_PER_SEC - 1));

    always_comb begin
        w_frame_d = r_frame;
        w_sec_d   = r_sec;
        w_min_d   = r_min;
        w_hour_d  = r_hour;
        if (frame_start) begin
            // A minute press swallows any tick landing on the same strobe.
            if (w_min_press) begin
                w_min_d   = (r_min == time6_t'(MINS_PER_HOUR - 1)) ? '0 : r_min + 6'd1;
                w_sec_d   = '0;
                w_frame_d = '0;
            end else if (w_tick) begin
                w_frame_d = '0;
                if (r_sec == time6_t'(SECS_PER_MIN - 1)) begin
                    w_sec_d = '0;
                    if (r_min == time6_t'(MINS_PER_HOUR - 1)) begin
                        w_min_d  = '0;
                        w_hour_d = (r_hour == hour_t'(HOURS - 1)) ? '0 : r_hour + 4'd1;
                    end else begin
                        w_min_d = r_min + 6'd1;
                    end
                end else begin
                    w_sec_d = r_sec + 6'd1;
                end
            end else if (run) begin
                w_frame_d = r_frame + 7'd1;
            end
            // Hour press stacks on top of whatever carry the tick produced.
            if (w_hour_press) begin
                w_hour_d = (w_hour_d == hour_t'(HOURS - 1)) ? '0 : w_hour_d + 4'd1;
            end
        end
    end

    always_ff @(posedge vga_clk or negedge vga_rst_n) begin
        if (!vga_rst_n) begin
            r_frame      <= '0;
            r_sec        <= '0;
            r_min        <= '0;
            r_hour       <= '0;
            r_sec_pos    <= '0;
            r_min_pos    <= '0;
            r_hour_pos   <= '0;
            r_pos_update <= 1'b0;
        end else begin
            r_frame      <= w_frame_d;
            r_sec        <= w_sec_d;
            r_min        <= w_min_d;
            r_hour       <= w_hour_d;
            r_pos_update <= frame_start;
            if (frame_start) begin
                r_sec_pos  <= w_sec_d;
                r_min_pos  <= w_min_d;
                r_hour_pos <= hour_pos_f(w_hour_d, w_min_d);
            end
        end
    end

    assign sec        = r_sec;
    assign min        = r_min;
    assign hour       = r_hour;
    assign sec_pos    = r_sec_pos;
    assign min_pos    = r_min_pos;
    assign hour_pos   = r_hour_pos;
    assign pos_update = r_pos_update;

endmodule

// File: tb/tb_clock_time.sv
// Directed, table-driven bench for clock_time: ticks, rollover, buttons, run and reset.
module tb_clock_time;

    localparam int unsigned Deb = 3;

    logic       vga_clk = 1'b0;
    logic       vga_rst_n = 1'b0;
    logic       frame_start = 1'b0;
    logic       btn_min_n = 1'b1;
    logic       btn_hour_n = 1'b1;
    logic       run = 1'b0;
    logic [5:0] sec;
    logic [5:0] min;
    logic [3:0] hour;
    logic [5:0] sec_pos;
    logic [5:0] min_pos;
    logic [5:0] hour_pos;
    logic       pos_update;

    int n_vec = 0;
    int n_err = 0;

    always #5 vga_clk = ~vga_clk;

    clock_time #(
        .FRAMES_PER_SEC (75),
        .DEBOUNCE_FRAMES(Deb)
    ) dut (
        .vga_clk    (vga_clk),
        .vga_rst_n  (vga_rst_n),
        .frame_start(frame_start),
        .btn_min_n  (btn_min_n),
        .btn_hour_n (btn_hour_n),
        .run        (run),
        .sec        (sec),
        .min        (min),
        .hour       (hour),
        .sec_pos    (sec_pos),
        .min_pos    (min_pos),
        .hour_pos   (hour_pos),
        .pos_update (pos_update)
    );

    typedef enum {OpStrobe, OpMin, OpHour} op_e;
    typedef struct {
        op_e op;
        int  cnt;
        bit  run;
        int  es;
        int  em;
        int  eh;
        int  ehp;
    } vec_t;

    vec_t tab[23];

    task automatic check_bit(input string name, input logic got, input logic want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %b, want %b", name, got, want);
        end
    endtask

    task automatic check_time(input string name, input int es, input int em, input int eh,
                              input int ehp);
        n_vec++;
        if ({sec, min, hour, sec_pos, min_pos, hour_pos} !==
            {6'(es), 6'(em), 4'(eh), 6'(es), 6'(em), 6'(ehp)}) begin
            n_err++;
            $display("FAIL %s: got %0d:%0d:%0d pos %0d/%0d/%0d, want %0d:%0d:%0d pos %0d/%0d/%0d",
                     name, hour, min, sec, sec_pos, min_pos, hour_pos,
                     eh, em, es, es, em, ehp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge vga_clk);
    endtask

    // One-cycle strobe; pos_update must pulse exactly on the following cycle.
    task automatic strobe();
        @(negedge vga_clk);
        frame_start = 1'b1;
        @(negedge vga_clk);
        frame_start = 1'b0;
        check_bit("pos_update_pulse", pos_update, 1'b1);
        @(posedge vga_clk);
        #1;
        check_bit("pos_update_clear", pos_update, 1'b0);
    endtask

    task automatic press(input bit is_min);
        if (is_min) btn_min_n = 1'b0;
        else        btn_hour_n = 1'b0;
        idle(3);
        repeat (Deb) strobe();
        btn_min_n  = 1'b1;
        btn_hour_n = 1'b1;
        idle(3);
        repeat (Deb) strobe();
    endtask

    task automatic apply(input vec_t v, input int idx);
        run = v.run;
        case (v.op)
            OpStrobe: repeat (v.cnt) strobe();
            OpMin:    repeat (v.cnt) press(1'b1);
            default:  repeat (v.cnt) press(1'b0);
        endcase
        check_time($sformatf("vec%0d", idx), v.es, v.em, v.eh, v.ehp);
    endtask

    initial begin
        tab[0]  = '{OpStrobe,   74, 1'b1,  0,  0,  0,  0};
        tab[1]  = '{OpStrobe,    1, 1'b1,  1,  0,  0,  0};
        tab[2]  = '{OpStrobe,  200, 1'b0,  1,  0,  0,  0};
        tab[3]  = '{OpHour,      3, 1'b0,  1,  0,  3, 15};
        tab[4]  = '{OpMin,      36, 1'b0,  0, 36,  3, 18};
        tab[5]  = '{OpHour,      2, 1'b0,  0, 36,  5, 28};
        tab[6]  = '{OpMin,      44, 1'b0,  0, 20,  5, 26};
        tab[7]  = '{OpStrobe, 3075, 1'b1, 41, 20,  5, 26};
        tab[8]  = '{OpMin,       1, 1'b0,  0, 21,  5, 26};
        tab[9]  = '{OpHour,      6, 1'b0,  0, 22, 11, 56};
        tab[10] = '{OpMin,      37, 1'b0,  0, 59, 11, 59};
        tab[11] = '{OpStrobe, 4425, 1'b1, 59, 59, 11, 59};
        tab[12] = '{OpStrobe,   75, 1'b1,  0,  0,  0,  0};
        tab[13] = '{OpHour,     11, 1'b0,  0,  0, 11, 55};
        tab[14] = '{OpMin,      59, 1'b0,  0, 59, 11, 59};
        tab[15] = '{OpStrobe, 4425, 1'b1, 59, 59, 11, 59};
        tab[16] = '{OpStrobe,   72, 1'b1, 59, 59, 11, 59};
        tab[17] = '{OpHour,      1, 1'b1,  0,  0,  1,  5};
        tab[18] = '{OpHour,      1, 1'b0,  0,  0,  2, 10};
        tab[19] = '{OpMin,      10, 1'b0,  0, 10,  2, 10};
        tab[20] = '{OpStrobe, 4425, 1'b1, 59, 10,  2, 10};
        tab[21] = '{OpStrobe,   72, 1'b1, 59, 10,  2, 10};
        tab[22] = '{OpMin,       1, 1'b1,  0, 11,  2, 10};

        idle(3);
        check_time("reset_state", 0, 0, 0, 0);
        check_bit("reset_pos_update", pos_update, 1'b0);
        vga_rst_n = 1'b1;
        idle(2);

        for (int i = 0; i <= 8; i++) apply(tab[i], i);

        // Two-strobe glitch must not be accepted.
        run = 1'b0;
        btn_min_n = 1'b0;
        idle(3);
        repeat (2) strobe();
        btn_min_n = 1'b1;
        idle(3);
        repeat (Deb) strobe();
        check_time("min_glitch", 0, 21, 5, 26);

        // Long hold yields exactly one increment.
        btn_min_n = 1'b0;
        idle(3);
        repeat (100) strobe();
        btn_min_n = 1'b1;
        idle(3);
        repeat (Deb) strobe();
        check_time("min_hold100", 0, 22, 5, 26);

        for (int i = 9; i < 23; i++) apply(tab[i], i);

        // Asynchronous reset mid-count, then restart from a cleared frame counter.
        run = 1'b1;
        repeat (5) strobe();
        @(negedge vga_clk);
        #2;
        vga_rst_n = 1'b0;
        #1;
        check_time("async_reset", 0, 0, 0, 0);
        check_bit("async_reset_pu", pos_update, 1'b0);
        @(negedge vga_clk);
        vga_rst_n = 1'b1;
        idle(5);
        check_time("post_reset_idle", 0, 0, 0, 0);
        check_bit("post_reset_pu", pos_update, 1'b0);
        repeat (74) strobe();
        check_time("post_reset_74", 0, 0, 0, 0);
        strobe();
        check_time("post_reset_tick", 1, 0, 0, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/clock_time.md
# clock_time

Wall-clock timekeeper and hand-position generator that sits directly upstream of the VGA renderer's clock-hand tiles. It derives 1 Hz from the renderer's frame strobe and keeps hours, minutes and seconds. It accepts debounced set buttons and publishes hand positions (0–59) for the second, minute and hour hands. Hand outputs change only at frame start, so the tile hit-test never sees a mid-frame change.

## Interface

Parameters:
- FRAMES_PER_SEC, 75, frame strobes per second (31.5 MHz / (840·500)).
- DEBOUNCE_FRAMES, 3, consecutive frames a button level must be stable before it is accepted.

Ports:
- vga_clk  in  1  pixel clock; the only clock.
- vga_rst_n  in  1  reset, asynchronous assert, active-low.
- frame_start  in  1  one-cycle pulse from the renderer at the first non-visible line (y == 480, x == 0).
- btn_min_n  in  1  raw, asynchronous, active-low "advance minute" button.
- btn_hour_n  in  1  raw, asynchronous, active-low "advance hour" button.
- run  in  1  1 = time advances; 0 = time frozen (buttons still act).
- sec  out  6  seconds, 0–59.
- min  out  6  minutes, 0–59.
- hour  out  4  hours, 0–11.
- sec_pos  out  6  second-hand position, 0–59.
- min_pos  out  6  minute-hand position, 0–59.
- hour_pos  out  6  hour-hand position, 0–59.
- pos_update  out  1  one-cycle pulse; the *_pos outputs changed this cycle.

## Operation

- **Reset:** all outputs 0, frame counter 0, debouncers idle with the "released" level accepted.
- **Buttons:** pass through a two-flop synchronizer, then each goes to a debouncer clocked by vga_clk and sampled at frame_start.
  - The accepted level changes after DEBOUNCE_FRAMES consecutive frame samples of the new level.
  - The press event is the accepted level going released → pressed. It lasts one cycle, coincident with a frame_start.
  - There is no auto-repeat.
- **Frame counter:** 7 bits, counts frame_start while run = 1.
  - At value FRAMES_PER_SEC−1 plus a strobe, it wraps to 0 and generates a tick.
  - While run = 0 the counter holds.
- **Tick:** sec increments. 59 → 0 carries into min; min 59 → 0 carries into hour; hour 11 → 0.
- **Minute press:** min ← (min + 1) mod 60, sec ← 0, frame counter ← 0. It never carries into hour.
- **Hour press:** hour ← (hour + 1) mod 12, with no effect on other fields.
- **Ordering within one frame_start:**
  - A minute press overrides the tick entirely; the tick is discarded.
  - An hour press is applied after the tick's carry: 11:59:59 with tick and hour press gives 1:00:00.
  - Both presses together: apply both rules.
- **Positions:** computed from the time values after the update above.
  - sec_pos = sec, min_pos = min.
  - hour_pos = hour·5 + min/12 (integer division; range 0–59).
  - All are registered, updated the cycle after frame_start, and pos_update pulses that same cycle.
- **frame_start while already high:** each cycle high is a separate strobe, and the renderer guarantees one-cycle pulses. The bench must not rely on this case.

## Timing

- All state updates occur on the vga_clk edge sampling frame_start = 1 (cycle N).
- sec/min/hour are visible at cycle N+1. *_pos and pos_update are visible at N+1 as well; one pipelined compute stage is allowed only if both land at N+1.
- Outputs are constant between frame_start pulses. No output changes without a frame_start, except on reset.
- Button path latency: synchronizer (2 cycles) + DEBOUNCE_FRAMES strobes. A clean press is acted on at the DEBOUNCE_FRAMES-th frame_start after it reaches the synchronizer output.
- Reset asserted mid-operation: all state clears immediately (asynchronous). The first update after deassert requires a new frame_start.

## Structure

- Shared package clock_time_pkg holds:
  - constants SECS_PER_MIN = 60, MINS_PER_HOUR = 60, HOURS = 12, POS_STEPS = 60, HOUR_POS_STEP = 5;
  - types time6_t (6-bit) and hour_t (4-bit).
- Sub-module frame_debounce (synchronizer + stability counter + edge detect), parameterized by DEBOUNCE_FRAMES and instantiated twice.
- Top level holds the frame counter, the time counters and the position registers.

## Test plan

- **Second tick:** reset, run = 1, 75 frame_start pulses. Expect sec = 1 and sec_pos = 1 one cycle after the 75th pulse, and pos_update high once per pulse.
- **Full rollover:** preload via buttons to 11:59:59, then 75 strobes. Expect 0:00:00 and hour_pos = 0. Then 11:59:00 gives hour_pos = 59.
- **Hour interpolation:** reach 3:36:00. Expect hour_pos = 18 and min_pos = 36.
- **Minute button:** hold btn_min_n low across 3 strobes from 5:20:41.
  - Expect 5:21:00 after the 3rd strobe.
  - A 2-strobe glitch produces no change.
  - Holding for 100 strobes gives a single increment.
- **Simultaneous events:**
  - 11:59:59 with tick and hour press in the same strobe gives 1:00:00.
  - Tick and minute press in the same strobe from 2:10:59 gives 2:11:00.
- **run and reset:** with run = 0, 200 strobes leave time unchanged. Asserting vga_rst_n low mid-count clears all outputs to 0 within the same cycle, with no further change until a post-reset strobe.
